sipo_rx: RTL and testbench

//   Serial-in parallel-out receiver: the receive end of our MSB-first serial shifter link.

---
 rtl/sipo_rx.sv | 127 ++++++++++++
 tb/tb_sipo_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx : serial-in parallel-out receiver (receive end of the serial link)
//
// Samples serial_in on every rising clk edge where shift_en is high, assembles
// WIDTH-bit words and offers each finished word on a one-entry valid/ready
// holding register.  A word that completes while the holding register is full
// and is not being accepted on that same edge is dropped, and the sticky
// overrun flag is set.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   clear         in   synchronous abort: drops the partial word, empties the
//                      holding register and clears overrun.  parallel_out holds.
//   serial_in     in   serial data bit
//   shift_en      in   qualifies serial_in (one bit per cycle when high)
//   parallel_out  out  assembled word, meaningful while out_valid=1
//   out_valid     out  holding register contains a word
//   out_ready     in   consumer accepts the word
//   overrun       out  sticky: a completed word was dropped
//   bit_count     out  bits collected in the current partial word
//
// Handshake: a word transfers on any rising edge where out_valid=1 and
// out_ready=1.  While out_valid=1 and no transfer happens, parallel_out stays
// stable.  out_ready has no effect while out_valid=0.
// -----------------------------------------------------------------------------
module sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     serial_in,
  input  logic                     shift_en,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q,    sr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;

  logic [WIDTH-1:0] sr_shifted;
  logic             accept;
  logic             complete;

  // Shift direction decides which end of the word the first bit ends up in.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shifted = {sr_q[WIDTH-2:0], serial_in};
    end else begin
      sr_shifted = {serial_in, sr_q[WIDTH-1:1]};
    end
  end

  assign accept   = valid_q & out_ready;
  assign complete = shift_en & (cnt_q == LAST_BIT);

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (clear) begin
      sr_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (accept) begin
        valid_d = 1'b0;
      end

      if (shift_en) begin
        // The shift register is fully overwritten by the next WIDTH bits, so
        // it needs no explicit clearing after a word completes.
        sr_d = sr_shifted;
        if (complete) begin
          cnt_d = '0;
          // Holding register is free if it was empty or is being drained on
          // this very edge; otherwise the new word is lost.
          if (!valid_q || accept) begin
            data_d  = sr_shifted;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = data_q;
  assign out_valid    = valid_q;
  assign overrun      = ovr_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx : bench for sipo_rx (WIDTH=8), one instance per bit order, both
// fed from the same inputs.
// -----------------------------------------------------------------------------
module tb_sipo_rx;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic serial_in = 1'b0;
  logic shift_en = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] pout_m, pout_l;
  logic         val_m, val_l, ovr_m, ovr_l;
  logic [2:0]   cnt_m, cnt_l;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .clear(clear), .serial_in(serial_in),
    .shift_en(shift_en), .parallel_out(pout_m), .out_valid(val_m),
    .out_ready(out_ready), .overrun(ovr_m), .bit_count(cnt_m)
  );

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .clear(clear), .serial_in(serial_in),
    .shift_en(shift_en), .parallel_out(pout_l), .out_valid(val_l),
    .out_ready(out_ready), .overrun(ovr_l), .bit_count(cnt_l)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- reference model
  // Bits of the current partial word in arrival order; a word is formed from
  // them once W have arrived.
  bit           bq[$];
  logic         m_valid, m_ovr;
  logic [W-1:0] m_dm, m_dl;
  logic [W-1:0] exp_q[$];   // words the consumer should receive, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dm    = '0;
    m_dl    = '0;
    exp_q.delete();
  endtask

  function automatic void model_step(input bit se, input bit si, input bit rdy, input bit clr);
    logic [W-1:0] wm, wl;
    if (clr) begin
      bq.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      exp_q.delete();
      return;
    end
    if (m_valid && rdy) m_valid = 1'b0;
    if (se) begin
      bq.push_back(si);
      if (bq.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bq[i];
          wl[i]     = bq[i];
        end
        if (!m_valid) begin
          m_dm    = wm;
          m_dl    = wl;
          m_valid = 1'b1;
          exp_q.push_back(wm);
        end else begin
          m_ovr = 1'b1;
        end
        bq.delete();
      end
    end
  endfunction

  task automatic check_all();
    check("msb_data",  pout_m, m_dm);
    check("lsb_data",  pout_l, m_dl);
    check("msb_valid", val_m,  m_valid);
    check("lsb_valid", val_l,  m_valid);
    check("msb_ovr",   ovr_m,  m_ovr);
    check("lsb_ovr",   ovr_l,  m_ovr);
    check("msb_cnt",   cnt_m,  bq.size());
    check("lsb_cnt",   cnt_l,  bq.size());
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Called just after a rising edge; drives, runs the edge, samples 1ns later.
  task automatic tick(input bit se, input bit si, input bit rdy, input bit clr);
    shift_en  = se;
    serial_in = si;
    out_ready = rdy;
    clear     = clr;
    #2;
    if (val_m && rdy && !clr) begin
      if (exp_q.size() == 0) begin
        check("accept_unexpected", 32'd1, 32'd0);
      end else begin
        check("accepted_word", pout_m, exp_q.pop_front());
      end
    end
    @(posedge clk);
    model_step(se, si, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
    for (int i = 0; i < W; i++) tick(1'b1, w[W-1-i], (i == W-1) ? rdy_last : 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse between edges; outputs must drop before any edge.
  task automatic reset_pulse();
    reset = 1'b1;
    model_reset();
    #1;
    check("areset_data",  pout_m, 0);
    check("areset_valid", val_m,  0);
    check("areset_ovr",   ovr_m,  0);
    check("areset_cnt",   cnt_m,  0);
    check_all();
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit           se, si, rdy, clr;
    logic [W-1:0] exp_data;
    logic         exp_valid, exp_ovr;
    logic [2:0]   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit se, input bit si, input bit rdy, input bit clr,
                                  input logic [W-1:0] d, input logic v, input logic o,
                                  input logic [2:0] c);
    vec_t x;
    x.se = se; x.si = si; x.rdy = rdy; x.clr = clr;
    x.exp_data = d; x.exp_valid = v; x.exp_ovr = o; x.exp_cnt = c;
    vecs.push_back(x);
  endfunction

  // ---------------------------------------------------------------- test sequence
  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] lsb_bits;

    model_reset();
    #1;
    check_all();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // A5 with out_ready low, then FF into the full register, then drain, then clear.
    pat = 8'hA5;
    for (int i = 0; i < W; i++)
      add_vec(1'b1, pat[W-1-i], 1'b0, 1'b0, (i == W-1) ? 8'hA5 : 8'h00,
              (i == W-1), 1'b0, 3'((i + 1) % W));
    for (int i = 0; i < W; i++)
      add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, (i == W-1), 3'((i + 1) % W));
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 3'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd0);

    foreach (vecs[k]) begin
      tick(vecs[k].se, vecs[k].si, vecs[k].rdy, vecs[k].clr);
      check("tbl_data",  pout_m, vecs[k].exp_data);
      check("tbl_valid", val_m,  vecs[k].exp_valid);
      check("tbl_ovr",   ovr_m,  vecs[k].exp_ovr);
      check("tbl_cnt",   cnt_m,  vecs[k].exp_cnt);
    end

    // 3C with a one-cycle gap after every bit; count must hold across gaps.
    pat = 8'h3C;
    for (int i = 0; i < W; i++) begin
      tick(1'b1, pat[W-1-i], 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("gap_cnt_hold", cnt_m, (i + 1) % W);
    end
    check("gap_data",  pout_m, 8'h3C);
    check("gap_valid", val_m,  1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Completion coinciding with acceptance of the held word.
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b1);
    check("swap_valid", val_m,  1);
    check("swap_data",  pout_m, 8'h5A);
    check("swap_ovr",   ovr_m,  0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-word, then a clean word.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_cnt", cnt_m, 0);
    send_word(8'h81, 1'b0);
    check("clear_word", pout_m, 8'h81);

    // Reset mid-word with a word still held, then a clean word.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    reset_pulse();
    send_word(8'h81, 1'b0);
    check("reset_word", pout_m, 8'h81);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first ordering: bits 1,0,1,0,0,1,0,1 in arrival order.
    lsb_bits = 8'b1010_0101;
    for (int i = 0; i < W; i++) tick(1'b1, lsb_bits[W-1-i], 1'b0, 1'b0);
    check("lsb_word", pout_l, 8'hA5);
    check("lsb_valid_word", val_l, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
      if (n == 300) reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
